// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
//   Fetch/decode/execute controller for the 8-bit CPU. Owns only the
//   instruction sequencing state. The PC, IR, accumulator, ALU and output
//   register live in the datapath and are steered by the strobes below.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   run        in   permits new instruction fetches
//   instr      in   [7:0] instruction word (opcode [7:4], operand [3:0])
//   mem_ready  in   memory completes the current access this cycle
//   zero_flag  in   accumulator == 0
//   pc_en      out  increment PC
//   pc_load    out  load PC from operand
//   ir_load    out  capture instr into IR
//   mem_req    out  memory access request
//   mem_we     out  write strobe (qualified by mem_req)
//   addr_sel   out  0 = PC address, 1 = operand address
//   alu_op     out  [1:0] 00 pass, 01 add, 10 sub
//   acc_load   out  load accumulator
//   acc_src    out  [1:0] 00 memory, 01 ALU, 10 immediate
//   out_load   out  load output register
//   halted     out  high in HALT or FAULT
//   fault      out  high in FAULT
//   state      out  [2:0] current state, for debug
module cpu_control_sequencer #(
  parameter int TIMEOUT = 15  // max wait cycles on mem_ready; 0 disables
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [1:0] alu_op,
  output logic       acc_load,
  output logic [1:0] acc_src,
  output logic       out_load,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMOP  = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Counter only has to reach TIMEOUT-1: the wait cycle that finds it there
  // is the TIMEOUT-th and triggers the fault.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        cur;
  logic [3:0]    opcode;
  logic [3:0]    operand;
  logic [CW-1:0] wait_cnt;
  logic          req;
  logic          timeout_hit;

  // The operand is held for debug visibility only; the datapath takes the
  // jump/memory address from its own IR copy.
  logic unused_operand;
  assign unused_operand = ^operand;

  // Ungated request: the reset branch of the state register dominates, so
  // the reset gating applied to the ports is not needed here.
  assign req         = ((cur == S_FETCH) && run) || (cur == S_MEMOP);
  assign timeout_hit = (TIMEOUT > 0) && req && !mem_ready && (wait_cnt == LAST);

  // NOTE: async reset in the sensitivity list and <= for every state
  // element, so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_FETCH;
      opcode   <= '0;
      operand  <= '0;
      wait_cnt <= '0;
    end else begin
      // Counts consecutive stalled request cycles; any non-waiting cycle
      // (including the idle cycles between requests) clears it.
      if (req && !mem_ready) wait_cnt <= wait_cnt + CW'(1);
      else                   wait_cnt <= '0;

      case (cur)
        S_FETCH: begin
          if (run) begin
            if (mem_ready) begin
              opcode  <= instr[7:4];
              operand <= instr[3:0];
              cur     <= S_DECODE;
            end else if (timeout_hit) begin
              cur <= S_FAULT;
            end
          end
        end
        S_DECODE: cur <= S_EXEC;
        S_EXEC: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: cur <= S_MEMOP;
            OP_HLT:                         cur <= S_HALT;
            default:                        cur <= S_FETCH;
          endcase
        end
        S_MEMOP: begin
          if (mem_ready)        cur <= S_FETCH;
          else if (timeout_hit) cur <= S_FAULT;
        end
        S_HALT:  cur <= S_HALT;
        S_FAULT: cur <= S_FAULT;
        default: cur <= S_FAULT;
      endcase
    end
  end

  assign state = cur;

  // Strobes are a combinational decode so that the mem_ready cycle itself
  // carries ir_load/acc_load; reset forces them low even while the state
  // register already reads FETCH, which aborts an access immediately.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    ir_load  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    alu_op   = 2'b00;
    acc_load = 1'b0;
    acc_src  = 2'b00;
    out_load = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_load = 1'b1;
              pc_en   = 1'b1;
            end
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_LDI: begin
              acc_load = 1'b1;
              acc_src  = 2'b10;
            end
            OP_JMP:  pc_load  = 1'b1;
            OP_JZ:   pc_load  = zero_flag;
            OP_OUT:  out_load = 1'b1;
            default: ;
          endcase
        end
        S_MEMOP: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_STA);
          if (mem_ready) begin
            case (opcode)
              OP_LDA: acc_load = 1'b1;
              OP_ADD: begin
                acc_load = 1'b1;
                acc_src  = 2'b01;
                alu_op   = 2'b01;
              end
              OP_SUB: begin
                acc_load = 1'b1;
                acc_src  = 2'b01;
                alu_op   = 2'b10;
              end
              default: ;
            endcase
          end
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit CPU.
- Sequences the program counter (increment and load), the instruction register, the memory handshake, the ALU and the accumulator.
- Sits between the program counter, the memory interface and the ALU/accumulator datapath.
- Datapath registers live outside this block. It drives control strobes only.

Parameters:
- TIMEOUT, 15, maximum cycles to wait for mem_ready before entering FAULT. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  high permits new instruction fetches
- instr  in  8  instruction word; opcode = instr[7:4], operand = instr[3:0]. Sampled when ir_load is high; the decoded copy is held internally.
- mem_ready  in  1  memory completes the current access this cycle
- zero_flag  in  1  accumulator == 0, from the datapath
- pc_en  out  1  increment the program counter
- pc_load  out  1  load the program counter from operand (jumps)
- ir_load  out  1  capture instr into the instruction register
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- addr_sel  out  1  0 = address from PC, 1 = address from operand
- alu_op  out  2  00 pass, 01 add, 10 sub
- acc_load  out  1  load the accumulator
- acc_src  out  2  00 = memory data, 01 = ALU result, 10 = immediate operand
- out_load  out  1  load the output register
- halted  out  1  high in HALT or FAULT
- fault  out  1  high in FAULT
- state  out  3  current state encoding, for debug

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEMOP = 3, HALT = 4, FAULT = 5.
- State is registered. Control outputs are a combinational decode of state, the held opcode and mem_ready.
- Reset:
  - State goes to FETCH asynchronously.
  - Held opcode, operand and wait counter clear to 0.
  - Every control output is forced to 0 while reset is high, including mem_req.
  - Reset mid-access aborts the access immediately; no partial strobes are issued.
- FETCH:
  - If run = 0: idle, all outputs 0.
  - If run = 1: mem_req = 1, addr_sel = 0.
  - On the cycle mem_ready = 1: ir_load = 1 and pc_en = 1 (same cycle), then go to DECODE.
- DECODE: one cycle, no strobes, then EXEC.
- EXEC, by opcode. All instructions without a memory access take exactly 3 cycles with zero-wait memory (FETCH, DECODE, EXEC).
  - 0x0 NOP: back to FETCH.
  - 0x1 LDA, 0x2 ADD, 0x3 SUB, 0x4 STA: go to MEMOP.
  - 0x5 LDI: acc_load = 1, acc_src = 10, then FETCH.
  - 0x6 JMP: pc_load = 1, then FETCH.
  - 0x7 JZ: pc_load = zero_flag, then FETCH.
  - 0x8 OUT: out_load = 1, then FETCH.
  - 0xF HLT: go to HALT.
  - Any other opcode executes as NOP.
- MEMOP:
  - mem_req = 1, addr_sel = 1, held every cycle until mem_ready.
  - mem_we = 1 for STA only.
  - On the mem_ready cycle:
    - LDA: acc_load = 1, acc_src = 00.
    - ADD/SUB: acc_load = 1, acc_src = 01, alu_op = 01 or 10.
  - Then FETCH.
  - alu_op is 00 in every other case.
- Wait counter:
  - Counts consecutive cycles with mem_req = 1 and mem_ready = 0; clears on each new request.
  - If TIMEOUT > 0 and the count reaches TIMEOUT, go to FAULT on the next edge; no strobes are issued.
  - A mem_ready on the TIMEOUT-th wait cycle wins over the timeout.
- HALT and FAULT are terminal until reset. All strobes are 0; halted = 1. fault = 1 in FAULT only.
- run = 0 mid-instruction: the current instruction completes. The sequencer then idles in FETCH without requesting. It resumes on the first cycle run = 1.
- No two of pc_en, pc_load and ir_load are high in the same cycle, except pc_en with ir_load in FETCH.

Test Plan:
- Reset, then run = 1, mem_ready tied 1, instr = 0x00 → state cycles 0,1,2 repeating; pc_en pulses every 3 cycles; mem_req is high only in FETCH.
- instr = 0x53 (LDI 3), zero-wait memory → acc_load = 1 and acc_src = 10 in EXEC; next cycle is FETCH.
- instr = 0x25 (ADD [5]), mem_ready delayed 4 cycles in MEMOP → mem_req and addr_sel = 1 for 5 cycles; acc_load = 1 with alu_op = 01 only in the ready cycle.
- JZ with zero_flag = 0, then zero_flag = 1 → pc_load is 0, then 1; pc_en fires only in FETCH.
- TIMEOUT = 15, mem_ready held 0 in FETCH → after 15 wait cycles, state = 5 and fault = halted = 1; no ir_load. Assert reset → state = 0, all outputs 0.
- instr = 0xF0 → HALT after EXEC; further mem_ready or run toggles cause no strobes. Reset asserted mid-MEMOP during STA → mem_req and mem_we drop in the same cycle.
